// File: rtl/half_duplex_io_port.sv
// Active end of a single-bit shared pin: serialises a write word out,
// or releases the pin and deserialises a read word in, with a turnaround gap.
module half_duplex_io_port #(
  parameter int WIDTH       = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [WIDTH-1:0] wdata,
  inout  wire              io,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN,
    SAMPLE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             rw_q, rw_d;
  logic             oe_q, oe_d;
  logic             dout_q, dout_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH:0]   shin;

  // Shift-in view that also works for WIDTH = 1.
  assign shin = {sh_q, io};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      sh_q    <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      sh_q    <= sh_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    sh_d    = sh_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rw_d = rw;
          if (rw) begin
            state_d = TURN;
            tcnt_d  = TURN_LOAD;
            oe_d    = 1'b0;
          end else begin
            state_d = DRIVE;
            cnt_d   = CNT_LOAD;
            sh_d    = wdata << 1;
            dout_d  = wdata[WIDTH-1];
            oe_d    = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = TURN;
          tcnt_d  = TURN_LOAD;
          oe_d    = 1'b0;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          dout_d = sh_q[WIDTH-1];
          sh_d   = sh_q << 1;
        end
      end
      TURN: begin
        if (tcnt_q == '0) begin
          if (rw_q) begin
            state_d = SAMPLE;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        sh_d = shin[WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rdata_d = shin[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io    = oe_q ? dout_q : 1'bz;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_half_duplex_io_port.sv
// Bench for half_duplex_io_port: a 4-bit/1-turn instance on a pulled-up pin
// and a 1-bit/3-turn instance on a pulled-down pin, so release is visible.
module tb_half_duplex_io_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       start_a, rw_a, busy_a, done_a;
  logic [3:0] wdata_a, rdata_a, model_a;
  logic       tb_oe_a, tb_d_a;
  wire        io_a;

  logic       start_b, rw_b, busy_b, done_b;
  logic [0:0] wdata_b, rdata_b;
  logic       tb_oe_b, tb_d_b;
  wire        io_b;

  assign io_a = tb_oe_a ? tb_d_a : 1'bz;
  assign io_b = tb_oe_b ? tb_d_b : 1'bz;
  pullup (io_a);
  pulldown (io_b);

  half_duplex_io_port #(.WIDTH(4), .TURN_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rw(rw_a), .wdata(wdata_a),
    .io(io_a), .busy(busy_a), .done(done_a), .rdata(rdata_a)
  );

  half_duplex_io_port #(.WIDTH(1), .TURN_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rw(rw_b), .wdata(wdata_b),
    .io(io_b), .busy(busy_b), .done(done_b), .rdata(rdata_b)
  );

  // Reference: pin sequence is the word MSB first then one released cycle;
  // done follows on the next cycle and rdata keeps the last read word.
  task automatic write_a(input logic [3:0] w, input bit ign, input bit b2b);
    logic exp_q[$];
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i]);
    exp_q.push_back(1'b1);
    @(negedge clk);
    start_a = 1'b1; rw_a = 1'b0; wdata_a = w;
    @(negedge clk);
    start_a = 1'b0;
    for (int n = 0; n < exp_q.size(); n++) begin
      checks++;
      if (io_a !== exp_q[n] || busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL write_a w=%h cyc%0d: io=%b busy=%b done=%b, need io=%b busy=1 done=0",
                 w, n, io_a, busy_a, done_a, exp_q[n]);
      end
      if (ign && n == 1) begin
        start_a = 1'b1; rw_a = 1'b1; wdata_a = 4'hF;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || io_a !== 1'b1 || rdata_a !== model_a) begin
      errors++;
      $display("FAIL write_a_done w=%h: done=%b busy=%b io=%b rdata=%h, need 1 0 1 %h",
               w, done_a, busy_a, io_a, rdata_a, model_a);
    end
    if (b2b) begin
      start_a = 1'b1; rw_a = 1'b1;
    end
  endtask

  task automatic read_a(input logic [3:0] w, input bit pre);
    if (!pre) begin
      @(negedge clk);
      start_a = 1'b1; rw_a = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (io_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL read_a_turn: io=%b busy=%b done=%b, need 1 1 0", io_a, busy_a, done_a);
    end
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      tb_oe_a = 1'b1; tb_d_a = w[3-j];
      checks++;
      if (busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL read_a_sample%0d: busy=%b done=%b, need 1 0", j, busy_a, done_a);
      end
      @(negedge clk);
    end
    tb_oe_a = 1'b0;
    model_a = w;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || rdata_a !== model_a) begin
      errors++;
      $display("FAIL read_a_done: done=%b busy=%b rdata=%h, need 1 0 %h",
               done_a, busy_a, rdata_a, model_a);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || rdata_a !== 4'h0 || io_a !== 1'b1 ||
        busy_b !== 1'b0 || done_b !== 1'b0 || rdata_b !== 1'b0 || io_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: a=%b%b%h%b b=%b%b%b%b, need a=00 0 1 b=0000",
               busy_a, done_a, rdata_a, io_a, busy_b, done_b, rdata_b, io_b);
    end
  endtask

  task automatic test_write;
    write_a(4'b1011, 1'b0, 1'b0);
    write_a(4'b0100, 1'b0, 1'b0);
  endtask

  task automatic test_read;
    read_a(4'h6, 1'b0);
    read_a(4'h9, 1'b0);
  endtask

  task automatic test_ignored_start;
    write_a(4'h3, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_after: done=%b busy=%b, need 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_back_to_back;
    write_a(4'b1010, 1'b0, 1'b1);
    read_a(4'hC, 1'b1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] w;
      w = 4'($urandom);
      if ($urandom_range(0, 1) == 1) read_a(w, 1'b0);
      else write_a(w, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_op;
    bit seen;
    read_a(4'h5, 1'b0);
    @(negedge clk);
    start_a = 1'b1; rw_a = 1'b0; wdata_a = 4'hA;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    checks++;
    if (io_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre_drive: io=%b, need 0", io_a);
    end
    #1 rst = 1'b1;
    #1;
    model_a = 4'h0;
    checks++;
    if (io_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0 || rdata_a !== model_a) begin
      errors++;
      $display("FAIL reset_mid_op: io=%b busy=%b done=%b rdata=%h, need 1 0 0 0",
               io_a, busy_a, done_a, rdata_a);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_a !== 1'b0 || busy_a !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_done: done/busy seen=1, need 0");
    end
  endtask

  task automatic test_sweep;
    @(negedge clk);
    start_b = 1'b1; rw_b = 1'b0; wdata_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    checks++;
    if (io_b !== 1'b1 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL sweep_drive: io=%b busy=%b, need 1 1", io_b, busy_b);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (io_b !== 1'b0 || busy_b !== 1'b1 || done_b !== 1'b0) begin
        errors++;
        $display("FAIL sweep_turn%0d: io=%b busy=%b done=%b, need 0 1 0", n, io_b, busy_b, done_b);
      end
    end
    @(negedge clk);
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL sweep_wdone: done=%b busy=%b, need 1 0", done_b, busy_b);
    end
    @(negedge clk);
    start_b = 1'b1; rw_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (io_b !== 1'b0 || busy_b !== 1'b1 || done_b !== 1'b0) begin
        errors++;
        $display("FAIL sweep_rturn%0d: io=%b busy=%b done=%b, need 0 1 0", n, io_b, busy_b, done_b);
      end
      @(negedge clk);
    end
    tb_oe_b = 1'b1; tb_d_b = 1'b1;
    @(negedge clk);
    tb_oe_b = 1'b0;
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || rdata_b !== 1'b1) begin
      errors++;
      $display("FAIL sweep_rdone: done=%b busy=%b rdata=%b, need 1 0 1", done_b, busy_b, rdata_b);
    end
  endtask

  initial begin
    start_a = 1'b0; rw_a = 1'b0; wdata_a = 4'h0; model_a = 4'h0;
    tb_oe_a = 1'b0; tb_d_a = 1'b0;
    start_b = 1'b0; rw_b = 1'b0; wdata_b = 1'b0;
    tb_oe_b = 1'b0; tb_d_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_write;
    test_read;
    test_ignored_start;
    test_back_to_back;
    test_random;
    test_reset_mid_op;
    test_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
